// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Serialises icache fetches and dcache block reads, block writes and flush
// writes onto a single-ported RAM. Once the dcache is granted, the grant is
// held for up to BURST_LEN completed words. This keeps the words of one block
// together, so an instruction fetch cannot slip in between them. An icache
// grant always ends after one word.
//
// Optional build macro:
//   ARB_RR_EN  - round-robin tie-break between icache and dcache in IDLE,
//                using a one-bit "last served" flag. When the macro is not
//                defined, the dcache has fixed priority.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          icache read request and word address
//   iwait, iload         icache handshake (0 = done) and returned word
//   dREN, dWEN           dcache read / write request (mutually exclusive)
//   daddr, dstore        dcache word address and write data
//   dwait, dload         dcache handshake (0 = done) and returned word
//   ramREN, ramWEN       RAM read / write enables
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   grant_d              registered: dcache currently owns the RAM
//   err_count            saturating count of ERROR cycles while granted
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int BURST_LEN = 2,
    parameter int ERRCNT_W  = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                iREN,
    input  logic [31:0]         iaddr,
    output logic                iwait,
    output logic [31:0]         iload,
    input  logic                dREN,
    input  logic                dWEN,
    input  logic [31:0]         daddr,
    input  logic [31:0]         dstore,
    output logic                dwait,
    output logic [31:0]         dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [31:0]         ramaddr,
    output logic [31:0]         ramstore,
    input  logic [31:0]         ramload,
    input  logic [1:0]          ramstate,
    output logic                grant_d,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam int              CNT_W      = $clog2(BURST_LEN + 1);
    // The last word of a burst is reached when the count equals BURST_LEN-1.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);

    state_t             state;
    logic [CNT_W-1:0]   burst_cnt;

    logic dreq;
    logic ram_acc;
    logic ram_err;
    logic d_done;
    logic i_done;
    logic owner_active;
    logic err_inc;
    logic pick_d;

    assign dreq    = dREN | dWEN;
    assign ram_acc = (ramstate == RAM_ACCESS);
    assign ram_err = (ramstate == RAM_ERROR);
    assign d_done  = (state == DGRANT) && dreq && ram_acc;
    assign i_done  = (state == IGRANT) && iREN && ram_acc;

    assign owner_active = ((state == DGRANT) && dreq) || ((state == IGRANT) && iREN);
    assign err_inc      = owner_active && ram_err && (err_count != {ERRCNT_W{1'b1}});

`ifdef ARB_RR_EN
    // last_d = 1 when the dcache was granted most recently. On a tie, the
    // requester that was not served last wins. The reset value (icache-last)
    // lets the dcache win the first tie.
    logic last_d;

    assign pick_d = dreq && (!iREN || !last_d);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            last_d <= 1'b0;
        else if ((state == IDLE) && (dreq || iREN))
            last_d <= pick_d;
    end
`else
    assign pick_d = dreq;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            grant_d   <= 1'b0;
            burst_cnt <= '0;
            err_count <= '0;
        end else begin
            if (err_inc)
                err_count <= err_count + ERRCNT_W'(1);

            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (pick_d) begin
                        state   <= DGRANT;
                        grant_d <= 1'b1;
                    end else if (iREN) begin
                        state   <= IGRANT;
                        grant_d <= 1'b0;
                    end
                end
                DGRANT: begin
                    if (d_done) begin
                        // Hold the grant for the next word of the block. If the
                        // dcache then drops its request, the drop branch below
                        // releases the grant.
                        if (burst_cnt < BURST_LAST) begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                        end else begin
                            state     <= IDLE;
                            grant_d   <= 1'b0;
                            burst_cnt <= '0;
                        end
                    end else if (!dreq) begin
                        state     <= IDLE;
                        grant_d   <= 1'b0;
                        burst_cnt <= '0;
                    end
                end
                IGRANT: begin
                    if (i_done || !iREN)
                        state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    grant_d   <= 1'b0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // RAM side and requester returns. The RAM side is a pass-through of the
    // owner's live inputs, so the owner can change address or data while it
    // waits. An ERROR cycle keeps the enables asserted, so the access is
    // retried.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                dwait    = ~(dreq && ram_acc);
            end
            IGRANT: begin
                ramREN   = iREN;
                ramaddr  = iaddr;
                iload    = ramload;
                iwait    = ~(iREN && ram_acc);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        grant_d;
    logic [7:0]  err_count;

    // RAM status: driven by hand, or an auto responder that answers any enable
    // with ACCESS in the same cycle.
    logic        auto_ram;
    logic [1:0]  ram_st;
    always_comb ramstate = auto_ram ? ((ramREN | ramWEN) ? ACCESS : FREE) : ram_st;

    cache_mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .grant_d(grant_d), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] store;
        logic        wr;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    int n_vec  = 0;
    int n_miss = 0;
    int seq    = 0;
    int i_seq  = 0;
    int d_seq  = 0;
    bit ipend  = 1'b0;
    bit dpend  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_i(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a; e.data = d; e.store = '0; e.wr = 1'b0;
        iq.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] s, input logic w);
        exp_t e;
        e.addr = a; e.data = d; e.store = s; e.wr = w;
        dq.push_back(e);
    endtask

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: each completion pops the requester's queue and checks the
    // returned word and the address/data presented to the RAM.
    always @(negedge CLK) begin
        if (nRST) begin
            if (!iwait) begin
                chk("i_queue_nonempty", 32'(iq.size() != 0), 32'd1);
                if (iq.size() != 0) begin
                    exp_t e;
                    e = iq.pop_front();
                    chk("iload", iload, e.data);
                    chk("i_ramaddr", ramaddr, e.addr);
                end
                ipend = 1'b0;
                i_seq = seq;
                seq++;
            end
            if (!dwait) begin
                chk("d_queue_nonempty", 32'(dq.size() != 0), 32'd1);
                if (dq.size() != 0) begin
                    exp_t e;
                    e = dq.pop_front();
                    chk("dload", dload, e.data);
                    chk("d_ramaddr", ramaddr, e.addr);
                    chk("d_ramWEN", ramWEN, e.wr);
                    if (e.wr) chk("d_ramstore", ramstore, e.store);
                end
                dpend = 1'b0;
                d_seq = seq;
                seq++;
            end
        end
    end

    // Requests follow the pending flags, which the scoreboard clears on completion.
    task automatic run_auto(input int budget);
        for (int k = 0; k < budget; k++) begin
            cyc;
            iREN = ipend;
            dREN = dpend;
            if (!ipend && !dpend) break;
        end
        chk("auto_timeout", 32'(ipend | dpend), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        auto_ram = 1'b0; ram_st = FREE;
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        chk("rst_grant_d", grant_d, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Solo icache read: two BUSY cycles, then ACCESS.
        cyc; iREN = 1; iaddr = 32'h40; push_i(32'h40, 32'hDEADBEEF);
        #1 chk("t1_idle_no_ren", ramREN, 0);
        cyc; ram_st = BUSY;
        #1 chk("t1_ramREN", ramREN, 1); chk("t1_ramaddr", ramaddr, 32'h40); chk("t1_iwait_busy", iwait, 1);
        cyc; ram_st = BUSY;
        cyc; ram_st = ACCESS; ramload = 32'hDEADBEEF;
        cyc; iREN = 0; ram_st = FREE; ramload = 0;
        #1 chk("t1_back_idle", ramaddr, 0);

        // Two-word dcache read burst with a concurrent icache request.
        cyc; dREN = 1; daddr = 32'h3000; iREN = 1; iaddr = 32'h80;
        push_d(32'h3000, 32'hA1A1A1A1, 0, 0); push_i(32'h80, 32'hC0C0C0C0);
        #1 chk("t2_grant_d_idle", grant_d, 0);
        cyc; ram_st = BUSY;
        #1 chk("t2_grant_d", grant_d, 1); chk("t2_ramREN", ramREN, 1); chk("t2_ramaddr0", ramaddr, 32'h3000);
        cyc; ram_st = ACCESS; ramload = 32'hA1A1A1A1;
        cyc; daddr = 32'h3004; ram_st = BUSY; push_d(32'h3004, 32'hB2B2B2B2, 0, 0);
        #1 chk("t2_grant_held", grant_d, 1); chk("t2_ramaddr1", ramaddr, 32'h3004);
        cyc; ram_st = ACCESS; ramload = 32'hB2B2B2B2;
        cyc; dREN = 0; ram_st = FREE;
        #1 chk("t2_grant_released", grant_d, 0);
        cyc; ram_st = ACCESS; ramload = 32'hC0C0C0C0;
        #1 chk("t2_igrant_addr", ramaddr, 32'h80);
        cyc; iREN = 0; ram_st = FREE; ramload = 0;

        // Tie: dcache write wins and sees 3 ERROR retries; icache follows the burst.
        cyc; dWEN = 1; daddr = 32'h5000; dstore = 32'h12345678; iREN = 1; iaddr = 32'h44;
        push_d(32'h5000, 0, 32'h12345678, 1); push_i(32'h44, 32'h11112222);
        cyc; ram_st = ERROR;
        #1 chk("t3_ramWEN", ramWEN, 1); chk("t3_ramREN", ramREN, 0);
        chk("t3_ramaddr", ramaddr, 32'h5000); chk("t3_ramstore", ramstore, 32'h12345678);
        cyc; ram_st = ERROR;
        #1 chk("t3_retry_wen", ramWEN, 1);
        cyc; ram_st = ERROR;
        cyc; ram_st = ACCESS;
        #1 chk("t3_err_count", err_count, 3);
        cyc; daddr = 32'h5004; dstore = 32'h9ABCDEF0; push_d(32'h5004, 0, 32'h9ABCDEF0, 1);
        cyc; dWEN = 0; ram_st = FREE;
        cyc; ram_st = ACCESS; ramload = 32'h11112222;
        cyc; iREN = 0; ram_st = FREE; ramload = 0;

        // Dcache served alone, then a tie: round-robin favours icache.
        auto_ram = 1'b1; ramload = 32'h0BADF00D;
        daddr = 32'h7000; dpend = 1; dREN = 1; push_d(32'h7000, 32'h0BADF00D, 0, 0);
        run_auto(10);
        cyc;
        daddr = 32'h7010; iaddr = 32'h90; ipend = 1; dpend = 1; iREN = 1; dREN = 1;
        push_d(32'h7010, 32'h0BADF00D, 0, 0); push_i(32'h90, 32'h0BADF00D);
        run_auto(20);
        chk("t4_tie_icache_first", 32'(i_seq < d_seq), 32'(RR));
        auto_ram = 1'b0; ramload = 0;

        // err_count saturation over 300 ERROR cycles.
        cyc; iREN = 1; iaddr = 32'h100; ram_st = FREE; push_i(32'h100, 32'h55AA55AA);
        cyc; ram_st = ERROR;
        repeat (299) cyc;
        cyc; ram_st = ACCESS; ramload = 32'h55AA55AA;
        #1 chk("t5_err_sat", err_count, 8'hFF);
        cyc; iREN = 0; ram_st = FREE; ramload = 0;

        // Reset in the middle of a dcache grant.
        cyc; dREN = 1; daddr = 32'h6000;
        cyc; ram_st = BUSY;
        #1 chk("t6_pre_ren", ramREN, 1);
        #1 nRST = 1'b0;
        #1 chk("t6_ramREN", ramREN, 0); chk("t6_ramWEN", ramWEN, 0);
        chk("t6_dwait", dwait, 1); chk("t6_iwait", iwait, 1);
        chk("t6_err_count", err_count, 0); chk("t6_grant_d", grant_d, 0);
        chk("t6_ramaddr", ramaddr, 0);
        cyc; dREN = 0; ram_st = FREE;
        @(negedge CLK); nRST = 1'b1;
        cyc;
        #1 chk("t6_idle_after", ramREN, 0);

        chk("iq_drained", 32'(iq.size()), 0);
        chk("dq_drained", 32'(dq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
